image_ram_dp: RTL



---
 rtl/image_ram_pkg.sv | 21 ++
 rtl/image_ram_clear_fsm.sv | 76 +++++++
 rtl/image_ram_dp.sv | 121 ++++++++++++
 3 files changed

// File: rtl/image_ram_pkg.sv
// Shared types and constants for the image_ram_dp frame buffer.
// Optional build macro: IMAGE_RAM_OUTREG_EN (adds an output pipeline stage, RD_LAT = 2).
package image_ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

`ifdef IMAGE_RAM_OUTREG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    // True when the requested depth fits the address space and holds at least two words.
    function automatic bit depth_valid(input longint depth, input int a_width);
        return (depth >= 2) && (depth <= (longint'(1) << a_width));
    endfunction

endpackage

// File: rtl/image_ram_clear_fsm.sv
// Clear engine: sweeps a captured fill value through every memory location.
//
//   state | meaning
//   IDLE  | waiting for clr_start; external writes own the memory port
//   CLEAR | one fill write per cycle at clr_addr, ends after DEPTH-1
module image_ram_clear_fsm
    import image_ram_pkg::*;
#(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 16,
    parameter int DEPTH   = 2**A_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clr_start,
    input  logic [D_WIDTH-1:0] clr_value,
    output logic               clr_busy,
    output logic               clr_done,
    output logic               clr_we,
    output logic [A_WIDTH-1:0] clr_addr,
    output logic [D_WIDTH-1:0] clr_data
);

    localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(DEPTH - 1);

    clr_state_e         state, state_nxt;
    logic [A_WIDTH-1:0] addr_nxt;
    logic [D_WIDTH-1:0] fill, fill_nxt;
    logic               done_nxt;

    // State, sweep address, captured fill value and done pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            clr_addr <= '0;
            fill     <= '0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_addr <= addr_nxt;
            fill     <= fill_nxt;
            clr_done <= done_nxt;
        end
    end

    // Next-state logic; a start request is only honoured from IDLE.
    always_comb begin
        state_nxt = state;
        addr_nxt  = clr_addr;
        fill_nxt  = fill;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_nxt = CLEAR;
                    addr_nxt  = '0;
                    fill_nxt  = clr_value;
                end
            end
            CLEAR: begin
                if (clr_addr == LAST_ADDR) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    addr_nxt = clr_addr + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign clr_busy = (state == CLEAR);
    assign clr_we   = (state == CLEAR);
    assign clr_data = fill;

endmodule

// File: rtl/image_ram_dp.sv
// Simple-dual-port image buffer with read-first read port and built-in clear engine.
// Optional build macro: IMAGE_RAM_OUTREG_EN registers rd_data/rd_valid once more.
module image_ram_dp
    import image_ram_pkg::*;
#(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 16,
    parameter int DEPTH   = 2**A_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [A_WIDTH-1:0] wr_addr,
    input  logic [D_WIDTH-1:0] wr_data,
    input  logic               rd_en,
    input  logic [A_WIDTH-1:0] rd_addr,
    output logic [D_WIDTH-1:0] rd_data,
    output logic               rd_valid,
    input  logic               clr_start,
    input  logic [D_WIDTH-1:0] clr_value,
    output logic               clr_busy,
    output logic               clr_done
);

    localparam bit DEPTH_OK = depth_valid(DEPTH, A_WIDTH);

    if (!DEPTH_OK) begin : g_depth_check
        $error("image_ram_dp: DEPTH must satisfy 2 <= DEPTH <= 2**A_WIDTH");
    end

    localparam logic [A_WIDTH:0] DEPTH_W = (A_WIDTH + 1)'(DEPTH);

    logic [D_WIDTH-1:0] mem [DEPTH];

    logic               clr_we;
    logic [A_WIDTH-1:0] clr_addr;
    logic [D_WIDTH-1:0] clr_data;
    logic               mem_we;
    logic [A_WIDTH-1:0] mem_waddr;
    logic [D_WIDTH-1:0] mem_wdata;
    logic               wr_in_range;
    logic               rd_in_range;
    logic [D_WIDTH-1:0] rd_data_q;
    logic               rd_valid_q;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

    image_ram_clear_fsm #(
        .D_WIDTH (D_WIDTH),
        .A_WIDTH (A_WIDTH),
        .DEPTH   (DEPTH)
    ) u_clear_fsm (
        .clock     (clock),
        .reset     (reset),
        .clr_start (clr_start),
        .clr_value (clr_value),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .clr_data  (clr_data)
    );

    // Write mux: the clear engine owns the port while sweeping; a reset edge aborts its write.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (clr_we) begin
            mem_we    = !reset;
            mem_waddr = clr_addr;
            mem_wdata = clr_data;
        end else if (wr_en && wr_in_range) begin
            mem_we = 1'b1;
        end
    end

    // Memory array write; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read; non-blocking update gives read-first behaviour on address collision.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= rd_in_range ? mem[rd_addr] : '0;
            end
        end
    end

`ifdef IMAGE_RAM_OUTREG_EN
    logic [D_WIDTH-1:0] rd_data_p;
    logic               rd_valid_p;

    // Output pipeline stage for block-RAM output register mapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_p  <= '0;
            rd_valid_p <= 1'b0;
        end else begin
            rd_data_p  <= rd_data_q;
            rd_valid_p <= rd_valid_q;
        end
    end

    assign rd_data  = rd_data_p;
    assign rd_valid = rd_valid_p;
`else
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

endmodule
